stream_transpose_buffer: RTL and testbench

- Sequential successor to the combinational dimension-swap block.
- Accepts a ROWS x COLS bit matrix one row (COLS bits) per beat over a valid/ready stream.
- Emits the transposed matrix one column (ROWS bits) per beat over a second valid/ready stream.
- Sits between producer and consumer stages of the datapath that need row-to-column reordering without holding the whole matrix on wide buses.

---
 rtl/stream_transpose_buffer.sv | 163 ++++++++++++++++
 tb/tb_stream_transpose_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stream_transpose_buffer.sv
// Row-in / column-out matrix transpose over valid/ready streams.
// Define TRANSPOSE_PINGPONG_EN for two banks so fill and drain overlap.
module stream_transpose_buffer #(
    parameter int ROWS = 4,
    parameter int COLS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [COLS-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ROWS-1:0] out_data,
    output logic            out_last,
    output logic            busy
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    logic [RW-1:0]   wr_idx_q, wr_idx_d;
    logic [CW-1:0]   rd_idx_q, rd_idx_d;
    logic            acc_s, xfer_s, wr_wrap_s, rd_wrap_s, any_full_s;
    logic [COLS-1:0] rd_rows_s [ROWS];

    assign acc_s     = in_valid & in_ready;
    assign xfer_s    = out_valid & out_ready;
    assign wr_wrap_s = acc_s & (wr_idx_q == ROW_LAST);
    assign rd_wrap_s = xfer_s & (rd_idx_q == COL_LAST);

    // Next-state for the row and column counters
    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (acc_s) begin
            wr_idx_d = wr_wrap_s ? '0 : wr_idx_q + RW'(1);
        end else begin
            wr_idx_d = wr_idx_q;
        end
        if (xfer_s) begin
            rd_idx_d = rd_wrap_s ? '0 : rd_idx_q + CW'(1);
        end else begin
            rd_idx_d = rd_idx_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
        end
    end

`ifdef TRANSPOSE_PINGPONG_EN
    logic            wb_q, rb_q;
    logic [1:0]      full_q, full_d;
    logic [COLS-1:0] mem_q [2][ROWS];

    assign in_ready   = ~full_q[wb_q];
    assign out_valid  = full_q[rb_q];
    assign any_full_s = |full_q;

    // A fill and a drain can only complete together on different banks
    always_comb begin
        full_d = full_q;
        if (wr_wrap_s) begin
            full_d[wb_q] = 1'b1;
        end else begin
            full_d[wb_q] = full_q[wb_q];
        end
        if (rd_wrap_s) begin
            full_d[rb_q] = 1'b0;
        end else begin
            full_d[rb_q] = full_d[rb_q];
        end
    end

    // Bank flags and bank pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 2'b00;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
        end else begin
            full_q <= full_d;
            wb_q   <= wb_q ^ wr_wrap_s;
            rb_q   <= rb_q ^ rd_wrap_s;
        end
    end

    // Row storage, left uncleared by reset
    always_ff @(posedge clk) begin
        if (acc_s && !reset) begin
            mem_q[wb_q][wr_idx_q] <= in_data;
        end
    end

    // Present the draining bank
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            rd_rows_s[r] = mem_q[rb_q][r];
        end
    end
`else
    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;
    state_e          state_q;
    logic [COLS-1:0] mem_q [ROWS];

    assign in_ready   = (state_q == FILL);
    assign out_valid  = (state_q == DRAIN);
    assign any_full_s = (state_q == DRAIN);

    // Single-bank fill/drain sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            case (state_q)
                FILL:    state_q <= wr_wrap_s ? DRAIN : FILL;
                DRAIN:   state_q <= rd_wrap_s ? FILL : DRAIN;
                default: state_q <= FILL;
            endcase
        end
    end

    // Row storage, left uncleared by reset
    always_ff @(posedge clk) begin
        if (acc_s && !reset) begin
            mem_q[wr_idx_q] <= in_data;
        end
    end

    // Present the single bank
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            rd_rows_s[r] = mem_q[r];
        end
    end
`endif

    // Column select; zero whenever nothing is offered
    always_comb begin
        out_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (out_valid) begin
                out_data[r] = rd_rows_s[r][rd_idx_q];
            end else begin
                out_data[r] = 1'b0;
            end
        end
    end

    assign out_last = out_valid & (rd_idx_q == COL_LAST);
    assign busy     = (wr_idx_q != '0) | any_full_s;

endmodule

// File: tb/tb_stream_transpose_buffer.sv
// Directed bench for stream_transpose_buffer: 4x8 and 2x5 instances, plus a
// 4x4 ping-pong instance when TRANSPOSE_PINGPONG_EN is defined.
module tb_stream_transpose_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv_a, ir_a, ov_a, ordy_a, ol_a, bsy_a;
    logic [7:0] id_a;
    logic [3:0] od_a;
    logic       iv_s, ir_s, ov_s, ordy_s, ol_s, bsy_s;
    logic [4:0] id_s;
    logic [1:0] od_s;
    int checks = 0;
    int errors = 0;

    stream_transpose_buffer #(.ROWS(4), .COLS(8)) dut_a (
        .clk(clk), .reset(rst), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
        .out_valid(ov_a), .out_ready(ordy_a), .out_data(od_a), .out_last(ol_a), .busy(bsy_a));

    stream_transpose_buffer #(.ROWS(2), .COLS(5)) dut_s (
        .clk(clk), .reset(rst), .in_valid(iv_s), .in_ready(ir_s), .in_data(id_s),
        .out_valid(ov_s), .out_ready(ordy_s), .out_data(od_s), .out_last(ol_s), .busy(bsy_s));

`ifdef TRANSPOSE_PINGPONG_EN
    logic       iv_p, ir_p, ov_p, ordy_p, ol_p, bsy_p;
    logic [3:0] id_p, od_p;
    stream_transpose_buffer #(.ROWS(4), .COLS(4)) dut_p (
        .clk(clk), .reset(rst), .in_valid(iv_p), .in_ready(ir_p), .in_data(id_p),
        .out_valid(ov_p), .out_ready(ordy_p), .out_data(od_p), .out_last(ol_p), .busy(bsy_p));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] row, input int gap);
        for (int g = 0; g < gap; g++) begin
            iv_a = 1'b0;
            chk("gap_ir", ir_a, 1'b1);
            chk("gap_ov", ov_a, 1'b0);
            step();
        end
        iv_a = 1'b1;
        id_a = row;
        chk("fill_ir", ir_a, 1'b1);
        chk("fill_ov", ov_a, 1'b0);
        chk("fill_od", od_a, 4'h0);
        step();
        iv_a = 1'b0;
        chk("fill_busy", bsy_a, 1'b1);
    endtask

    task automatic drain_a(input logic [31:0] exp, input int stall_col, input int stall_n,
                           input int ncols);
        for (int c = 0; c < ncols; c++) begin
            if (c == stall_col) begin
                for (int s = 0; s < stall_n; s++) begin
                    ordy_a = 1'b0;
                    chk("stall_ov", ov_a, 1'b1);
                    chk("stall_od", od_a, exp[c*4 +: 4]);
`ifndef TRANSPOSE_PINGPONG_EN
                    chk("stall_ir", ir_a, 1'b0);
`endif
                    step();
                end
            end
            ordy_a = 1'b1;
            chk("drain_ov", ov_a, 1'b1);
            chk("drain_od", od_a, exp[c*4 +: 4]);
            chk("drain_last", ol_a, (c == 7));
            chk("drain_busy", bsy_a, 1'b1);
`ifndef TRANSPOSE_PINGPONG_EN
            chk("drain_ir", ir_a, 1'b0);
`endif
            step();
        end
        ordy_a = 1'b0;
    endtask

    task automatic idle_a(input string tag);
        chk({tag, "_ov"}, ov_a, 1'b0);
        chk({tag, "_ir"}, ir_a, 1'b1);
        chk({tag, "_busy"}, bsy_a, 1'b0);
        chk({tag, "_od"}, od_a, 4'h0);
        chk({tag, "_last"}, ol_a, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        iv_a = 1'b0; id_a = 8'h00; ordy_a = 1'b0;
        iv_s = 1'b0; id_s = 5'b00000; ordy_s = 1'b0;
`ifdef TRANSPOSE_PINGPONG_EN
        iv_p = 1'b0; id_p = 4'h0; ordy_p = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_a("reset");
        chk("reset_s_ov", ov_s, 1'b0);
        chk("reset_s_ir", ir_s, 1'b1);
        chk("reset_s_busy", bsy_s, 1'b0);

        // Rows A5,3C,FF,00 -> columns 5,4,7,6,6,7,4,5; stall three cycles on column 2
        send_a(8'hA5, 0);
        send_a(8'h3C, 0);
        send_a(8'hFF, 0);
        send_a(8'h00, 0);
        drain_a(32'h5476_6745, 2, 3, 8);
        idle_a("post_bp");

        // Same frame with input gaps
        send_a(8'hA5, 0);
        send_a(8'h3C, 2);
        send_a(8'hFF, 2);
        send_a(8'h00, 2);
        drain_a(32'h5476_6745, -1, 0, 8);
        idle_a("post_gap");

        // Reset after three columns; the row offered during reset is dropped
        send_a(8'hA5, 0);
        send_a(8'h3C, 0);
        send_a(8'hFF, 0);
        send_a(8'h00, 0);
        drain_a(32'h5476_6745, -1, 0, 3);
        rst = 1'b1;
        iv_a = 1'b1;
        id_a = 8'hFF;
        step();
        rst = 1'b0;
        iv_a = 1'b0;
        idle_a("mid_reset");
        send_a(8'h01, 0);
        send_a(8'h02, 0);
        send_a(8'h04, 0);
        send_a(8'h08, 0);
        drain_a(32'h0000_8421, -1, 0, 8);
        idle_a("post_reset");

        // 2x5: rows 10000, 11111 -> 10,10,10,10,11
        iv_s = 1'b1;
        id_s = 5'b10000;
        chk("s_fill_ir0", ir_s, 1'b1);
        step();
        id_s = 5'b11111;
        chk("s_fill_ir1", ir_s, 1'b1);
        chk("s_fill_ov1", ov_s, 1'b0);
        step();
        iv_s = 1'b0;
        ordy_s = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("s_ov", ov_s, 1'b1);
            chk("s_od", od_s, (c == 4) ? 2'b11 : 2'b10);
            chk("s_last", ol_s, (c == 4));
            step();
        end
        chk("s_end_ov", ov_s, 1'b0);
        chk("s_end_busy", bsy_s, 1'b0);

`ifdef TRANSPOSE_PINGPONG_EN
        // Identity then all-ones frames back to back on the 4x4 ping-pong instance
        ordy_p = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (n < 8) begin
                iv_p = 1'b1;
                id_p = (n < 4) ? (4'b0001 << n) : 4'b1111;
                chk("pp_ir", ir_p, 1'b1);
            end else begin
                iv_p = 1'b0;
            end
            if (n >= 4) begin
                chk("pp_ov", ov_p, 1'b1);
                chk("pp_od", od_p, (n < 8) ? (4'b0001 << (n - 4)) : 4'b1111);
                chk("pp_last", ol_p, ((n % 4) == 3));
            end else begin
                chk("pp_ov0", ov_p, 1'b0);
            end
            step();
        end
        iv_p = 1'b0;
        chk("pp_end_ov", ov_p, 1'b0);
        chk("pp_end_busy", bsy_p, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
